// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back sequencer.
// Entry layout is fixed to the 5-bit address / 64-bit data register file.
package regfile_pkg;

    localparam logic [4:0] XZR_ADDR = 5'd31;
    localparam int         NUM_REGS = 32;

    typedef struct packed {
        logic [4:0]  wa;
        logic [63:0] wd;
    } wb_entry_t;

    // X31 reads as zero, so any write aimed at it is dropped.
    function automatic logic is_xzr(input logic [4:0] wa);
        return wa == XZR_ADDR;
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Result-source handshakes and register-file write port of the write-back sequencer.
// master = execute/memory side (and observer), slave = the sequencer.
interface regfile_writeback_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic                alu_valid;
    logic                alu_ready;
    logic [ADDR_W-1:0]   alu_wa;
    logic [DATA_W-1:0]   alu_wd;

    logic                ld_valid;
    logic                ld_ready;
    logic [ADDR_W-1:0]   ld_wa;
    logic [DATA_W-1:0]   ld_wd;

    logic                we3;
    logic [ADDR_W-1:0]   wa3;
    logic [DATA_W-1:0]   wd3;
    logic [NUM_REGS-1:0] pending;

    modport master (
        output alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
        input  alu_ready, ld_ready, we3, wa3, wd3, pending
    );

    modport slave (
        input  alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
        output alu_ready, ld_ready, we3, wa3, wd3, pending
    );

endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// In-order load-return buffer. Exposes every slot plus a per-slot valid vector
// so the parent can search for queued destinations without reading through the head.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push_i,
    input  wb_entry_t                   push_data_i,
    input  logic                        pop_i,
    output wb_entry_t                   head_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o,
    output logic [DEPTH-1:0]            valid_o,
    output wb_entry_t [DEPTH-1:0]       entries_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Payload needs no reset: a slot is only ever observed through valid_q.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (pop_i) begin
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push_i) begin
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign valid_o   = valid_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU results and buffered load returns onto the single register-file
// write port, keeping per-register write order and dropping writes to X31.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    regfile_writeback_if.slave wb
);

    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    wb_entry_t             push_data;
    wb_entry_t             cand;
    logic [DEPTH-1:0]      ent_valid;
    logic [CNT_W-1:0]      count;
    logic [NUM_REGS-1:0]   pending;

    logic full, empty, hazard;
    logic alu_ready, ld_ready, alu_acc, push, pop, cand_vld;

    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] wa3_q, wa3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .valid_o     (ent_valid),
        .entries_o   (entries)
    );

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                pending[entries[i].wa] = 1'b1;
            end
        end
        pending[XZR_ADDR] = 1'b0;
    end

    // An ALU write may not overtake an older queued load to the same register.
    assign hazard    = wb.alu_valid & ~is_xzr(wb.alu_wa) & pending[wb.alu_wa];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign ld_ready  = ~full;
    assign alu_ready = ~full & ~hazard;
    assign alu_acc   = wb.alu_valid & alu_ready;
    assign push      = wb.ld_valid & ld_ready;
    assign pop       = ~alu_acc & ~empty;

    assign push_data.wa = wb.ld_wa;
    assign push_data.wd = wb.ld_wd;

    always_comb begin
        cand_vld = 1'b0;
        cand     = head;
        if (alu_acc) begin
            cand_vld = 1'b1;
            cand.wa  = wb.alu_wa;
            cand.wd  = wb.alu_wd;
        end else if (pop) begin
            cand_vld = 1'b1;
        end
    end

    always_comb begin
        we3_d = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (cand_vld) begin
            we3_d = ~is_xzr(cand.wa);
            wa3_d = cand.wa;
            wd3_d = cand.wd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= we3_d;
            wa3_q <= wa3_d;
            wd3_q <= wd3_d;
        end
    end

    assign wb.alu_ready = alu_ready;
    assign wb.ld_ready  = ld_ready;
    assign wb.we3       = we3_q;
    assign wb.wa3       = wa3_q;
    assign wb.wd3       = wd3_q;
    assign wb.pending   = pending;

endmodule
